hamming_ecc_writer: RTL and testbench

Write-side Hamming (12,8) encoder stage for the dual-port memory.
- Accepts 8-bit write data plus address over a valid/ready handshake.
- Computes the 12-bit SEC codeword and presents it with the address on a registered valid/ready output that drives the memory write port.
- Contains a 2-entry skid buffer, so it sustains one word per clock with no combinational path from out_ready to in_ready.

---
 rtl/hamming_ecc_writer_pkg.sv | 24 ++
 rtl/hamming_ecc_writer_if.sv | 28 ++
 rtl/hamming_ecc_writer_parity_gen.sv | 33 +++
 rtl/hamming_ecc_writer.sv | 154 +++++++++++++++
 tb/tb_hamming_ecc_writer.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/hamming_ecc_writer_pkg.sv
// Shared definitions for the Hamming (12,8) write-side encoder.
// Codeword index i holds Hamming position i+1; parity sits at the power-of-two positions.
// Optional feature macro used elsewhere in this slice: HAMMING_ERR_INJECT_EN.
package hamming_pkg;

  localparam int DATA_W = 8;
  localparam int CODE_W = 12;
  localparam int PAR_W  = 4;

  // Codeword index of each parity bit (Hamming positions 1, 2, 4, 8)
  localparam int PAR_IDX [PAR_W] = '{0, 1, 3, 7};

  // Codeword index receiving each data bit d0..d7
  localparam int DATA_IDX [DATA_W] = '{2, 4, 5, 6, 8, 9, 10, 11};

  typedef logic [CODE_W-1:0] code_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } skid_state_e;

endpackage

// File: rtl/hamming_ecc_writer_if.sv
// Write-request and memory-side handshake bundle for hamming_ecc_writer.
// master = the surrounding system (requester plus memory port), slave = the encoder.
interface hamming_ecc_writer_if
  import hamming_pkg::*;
#(
  parameter int ADDR_W = 4
);

  logic              in_valid;
  logic              in_ready;
  logic [ADDR_W-1:0] in_addr;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [ADDR_W-1:0] out_addr;
  code_t             out_code;

  modport master (
    output in_valid, in_addr, in_data, out_ready,
    input  in_ready, out_valid, out_addr, out_code
  );

  modport slave (
    input  in_valid, in_addr, in_data, out_ready,
    output in_ready, out_valid, out_addr, out_code
  );

endinterface

// File: rtl/hamming_ecc_writer_parity_gen.sv
// Combinational Hamming (12,8) SEC encoder: scatters the data byte into its
// codeword positions, then forms each even-parity bit over the positions
// whose (index+1) has that parity bit's weight set.
module hamming_parity_gen
  import hamming_pkg::*;
(
  input  logic [DATA_W-1:0] data,
  output code_t             code
);

  code_t placed;
  logic  par;

  // Place data bits, then derive the four parity bits from the placed word
  always_comb begin
    placed = '0;
    par    = 1'b0;
    for (int d = 0; d < DATA_W; d++) begin
      placed[DATA_IDX[d]] = data[d];
    end
    code = placed;
    for (int k = 0; k < PAR_W; k++) begin
      par = 1'b0;
      for (int j = 0; j < CODE_W; j++) begin
        if (((j + 1) & (1 << k)) != 0) begin
          par = par ^ placed[j];
        end
      end
      code[PAR_IDX[k]] = par;
    end
  end

endmodule

// File: rtl/hamming_ecc_writer.sv
// Write-side Hamming (12,8) encoder stage with a 2-entry skid buffer.
// Accepted words are encoded and presented one cycle later; in_ready is
// registered so there is no combinational path from out_ready to in_ready.
// Optional macro HAMMING_ERR_INJECT_EN adds a one-shot single-bit error injector.
module hamming_ecc_writer
  import hamming_pkg::*;
#(
  parameter int ADDR_W = 4,
  parameter int CNT_W  = 16
)
(
  input  logic                clk,
  input  logic                rst,
  hamming_ecc_writer_if.slave bus,
`ifdef HAMMING_ERR_INJECT_EN
  input  logic                inj_arm,
  input  logic [3:0]          inj_pos,
`endif
  output logic [CNT_W-1:0]    enc_count
);

  skid_state_e       state_q, state_d;
  logic              in_ready_q, in_ready_d;
  logic              out_valid_q, out_valid_d;
  logic [ADDR_W-1:0] out_addr_q, out_addr_d;
  logic [ADDR_W-1:0] skid_addr_q, skid_addr_d;
  code_t             out_code_q, out_code_d;
  code_t             skid_code_q, skid_code_d;
  logic [CNT_W-1:0]  count_q, count_d;
  code_t             raw_code;
  code_t             flip_mask;
  code_t             new_code;
  logic              accept;

  assign accept = bus.in_valid & in_ready_q;

  hamming_parity_gen u_parity_gen (
    .data (bus.in_data),
    .code (raw_code)
  );

`ifdef HAMMING_ERR_INJECT_EN
  logic       armed_q, armed_d;
  logic [3:0] pos_q, pos_d;

  // Arm on the first inj_arm while idle; the next accepted word consumes the arm
  always_comb begin
    armed_d   = armed_q;
    pos_d     = pos_q;
    flip_mask = '0;
    for (int i = 0; i < CODE_W; i++) begin
      flip_mask[i] = armed_q && (int'(pos_q) == i);
    end
    if (!armed_q && inj_arm) begin
      armed_d = 1'b1;
      pos_d   = inj_pos;
    end else if (armed_q && accept) begin
      armed_d = 1'b0;
    end
  end

  // Injector state register
  always_ff @(posedge clk) begin
    if (rst) begin
      armed_q <= 1'b0;
      pos_q   <= '0;
    end else begin
      armed_q <= armed_d;
      pos_q   <= pos_d;
    end
  end
`else
  assign flip_mask = '0;
`endif

  assign new_code = raw_code ^ flip_mask;

  // Skid-buffer next state: output register first, overflow into the skid slot
  always_comb begin
    state_d     = state_q;
    out_addr_d  = out_addr_q;
    out_code_d  = out_code_q;
    skid_addr_d = skid_addr_q;
    skid_code_d = skid_code_q;
    count_d     = count_q;

    if (accept && (count_q != {CNT_W{1'b1}})) begin
      count_d = count_q + 1'b1;
    end

    unique case (state_q)
      EMPTY: begin
        if (accept) begin
          out_addr_d = bus.in_addr;
          out_code_d = new_code;
          state_d    = ONE;
        end
      end
      ONE: begin
        if (accept && bus.out_ready) begin
          out_addr_d = bus.in_addr;
          out_code_d = new_code;
        end else if (accept) begin
          skid_addr_d = bus.in_addr;
          skid_code_d = new_code;
          state_d     = TWO;
        end else if (bus.out_ready) begin
          state_d = EMPTY;
        end
      end
      TWO: begin
        if (bus.out_ready) begin
          out_addr_d = skid_addr_q;
          out_code_d = skid_code_q;
          state_d    = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase

    out_valid_d = (state_d != EMPTY);
    in_ready_d  = (state_d != TWO);
  end

  // Registered datapath, handshake flags and counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_addr_q  <= '0;
      out_code_q  <= '0;
      skid_addr_q <= '0;
      skid_code_q <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_addr_q  <= out_addr_d;
      out_code_q  <= out_code_d;
      skid_addr_q <= skid_addr_d;
      skid_code_q <= skid_code_d;
      count_q     <= count_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_addr  = out_addr_q;
  assign bus.out_code  = out_code_q;
  assign enc_count     = count_q;

endmodule

// File: tb/tb_hamming_ecc_writer.sv
// Self-checking bench for hamming_ecc_writer.
// Expected codewords come from an independent encoder written from the parity
// equations; accepted words are queued and compared in order as they leave.
// Define HAMMING_ERR_INJECT_EN to also exercise the error injector.
module tb_hamming_ecc_writer;

  logic        clk;
  logic        rst;
  logic [15:0] enc_count;
`ifdef HAMMING_ERR_INJECT_EN
  logic        inj_arm;
  logic [3:0]  inj_pos;
`endif

  hamming_ecc_writer_if #(.ADDR_W(4)) bus ();

  hamming_ecc_writer #(.ADDR_W(4), .CNT_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus.slave),
`ifdef HAMMING_ERR_INJECT_EN
    .inj_arm   (inj_arm),
    .inj_pos   (inj_pos),
`endif
    .enc_count (enc_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [15:0] sb [$];
  logic [15:0] model_count = 16'd0;
  logic [11:0] pending_mask = 12'h000;
  logic        last_in_fire = 1'b0;

  // Independent encoder written straight from the parity equations
  function automatic logic [11:0] ref_code(input logic [7:0] d);
    logic [11:0] c;
    c = 12'h000;
    c[2]  = d[0]; c[4] = d[1]; c[5]  = d[2]; c[6]  = d[3];
    c[8]  = d[4]; c[9] = d[5]; c[10] = d[6]; c[11] = d[7];
    c[0] = c[2] ^ c[4] ^ c[6] ^ c[8] ^ c[10];
    c[1] = c[2] ^ c[5] ^ c[6] ^ c[9] ^ c[10];
    c[3] = c[4] ^ c[5] ^ c[6] ^ c[11];
    c[7] = c[8] ^ c[9] ^ c[10] ^ c[11];
    return c;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    assert (observed === expected) else begin
      n_fail++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [3:0] a, input logic [7:0] d, input logic ordy);
    bus.in_valid  = v;
    bus.in_addr   = a;
    bus.in_data   = d;
    bus.out_ready = ordy;
  endtask

  // One clock: bookkeep transfers at the negedge, then step past the posedge
  task automatic cycle();
    logic [15:0] exp_entry;
    @(negedge clk);
    last_in_fire = 1'b0;
    if (!rst) begin
      if (bus.out_valid && bus.out_ready) begin
        checkOutput("sb_nonempty", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          exp_entry = sb.pop_front();
          checkOutput("out_addr", 32'(bus.out_addr), 32'(exp_entry[15:12]));
          checkOutput("out_code", 32'(bus.out_code), 32'(exp_entry[11:0]));
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        sb.push_back({bus.in_addr, ref_code(bus.in_data) ^ pending_mask});
        pending_mask = 12'h000;
        last_in_fire = 1'b1;
        if (model_count != 16'hFFFF) model_count = model_count + 16'd1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    applyStimulus(1'b0, 4'h0, 8'h00, 1'b1);
    for (int i = 0; i < 20; i++) begin
      if (sb.size() == 0 && !bus.out_valid) break;
      cycle();
    end
    checkOutput("drain_empty", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    logic [7:0]  bb_data [3];
    logic [11:0] bb_code [3];
    int          budget;

    bb_data = '{8'h00, 8'h01, 8'hFF};
    bb_code = '{12'h000, 12'h007, 12'hF77};

`ifdef HAMMING_ERR_INJECT_EN
    inj_arm = 1'b0;
    inj_pos = 4'd0;
`endif
    applyStimulus(1'b0, 4'h0, 8'h00, 1'b0);

    // Reset state
    rst = 1'b1;
    cycle();
    cycle();
    rst = 1'b0;
    checkOutput("rst_out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("rst_in_ready",  32'(bus.in_ready),  32'd1);
    checkOutput("rst_out_addr",  32'(bus.out_addr),  32'd0);
    checkOutput("rst_out_code",  32'(bus.out_code),  32'd0);
    checkOutput("rst_count",     32'(enc_count),     32'd0);

    // Single write A5 at address 3
    applyStimulus(1'b1, 4'd3, 8'hA5, 1'b1);
    cycle();
    checkOutput("single_valid", 32'(bus.out_valid), 32'd1);
    checkOutput("single_code",  32'(bus.out_code),  32'hA27);
    checkOutput("single_addr",  32'(bus.out_addr),  32'd3);
    checkOutput("single_count", 32'(enc_count),     32'd1);
    drain();

    // Back-to-back writes at full throughput
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 4'(i), bb_data[i], 1'b1);
      cycle();
      checkOutput("b2b_code",  32'(bus.out_code), 32'(bb_code[i]));
      checkOutput("b2b_ready", 32'(bus.in_ready), 32'd1);
    end
    drain();

    // Backpressure: fill both slots, stall a third, then release
    applyStimulus(1'b1, 4'd1, 8'h11, 1'b0);
    cycle();
    checkOutput("bp_one_ready", 32'(bus.in_ready),  32'd1);
    checkOutput("bp_one_valid", 32'(bus.out_valid), 32'd1);
    applyStimulus(1'b1, 4'd2, 8'h22, 1'b0);
    cycle();
    checkOutput("bp_two_ready", 32'(bus.in_ready), 32'd0);
    applyStimulus(1'b1, 4'd3, 8'h33, 1'b0);
    cycle();
    checkOutput("bp_stall_ready", 32'(bus.in_ready), 32'd0);
    checkOutput("bp_stall_code",  32'(bus.out_code), 32'(ref_code(8'h11)));
    checkOutput("bp_stall_count", 32'(enc_count),    32'(model_count));
    applyStimulus(1'b1, 4'd3, 8'h33, 1'b1);
    cycle();
    checkOutput("bp_release_ready", 32'(bus.in_ready), 32'd1);
    checkOutput("bp_release_code",  32'(bus.out_code), 32'(ref_code(8'h22)));
    cycle();
    drain();
    checkOutput("bp_count", 32'(enc_count), 32'(model_count));

    // Reset while holding two words: both must vanish
    applyStimulus(1'b1, 4'd5, 8'h5A, 1'b0);
    cycle();
    applyStimulus(1'b1, 4'd6, 8'hC3, 1'b0);
    cycle();
    checkOutput("rst2_pre_ready", 32'(bus.in_ready), 32'd0);
    applyStimulus(1'b0, 4'd0, 8'h00, 1'b0);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    sb.delete();
    model_count = 16'd0;
    checkOutput("rst2_out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("rst2_in_ready",  32'(bus.in_ready),  32'd1);
    checkOutput("rst2_count",     32'(enc_count),     32'd0);
    applyStimulus(1'b0, 4'd0, 8'h00, 1'b1);
    for (int i = 0; i < 3; i++) cycle();
    checkOutput("rst2_quiet", 32'(bus.out_valid), 32'd0);

    // All 256 data values under random backpressure
    for (int v = 0; v < 256; v++) begin
      budget = 0;
      do begin
        applyStimulus(1'b1, 4'(v), 8'(v), 1'($urandom_range(0, 1)));
        cycle();
        budget++;
      end while (!last_in_fire && budget < 64);
      checkOutput("exh_accepted", 32'(last_in_fire), 32'd1);
    end
    drain();
    checkOutput("exh_count", 32'(enc_count), 32'd256);

`ifdef HAMMING_ERR_INJECT_EN
    // One-shot injection at position 5, then a clean word
    applyStimulus(1'b0, 4'd0, 8'h00, 1'b1);
    inj_arm = 1'b1;
    inj_pos = 4'd5;
    cycle();
    inj_arm = 1'b0;
    pending_mask = 12'h020;
    applyStimulus(1'b1, 4'd7, 8'hA5, 1'b1);
    cycle();
    checkOutput("inj_flip_code", 32'(bus.out_code), 32'hA07);
    applyStimulus(1'b1, 4'd8, 8'hA5, 1'b1);
    cycle();
    checkOutput("inj_clean_code", 32'(bus.out_code), 32'hA27);
    drain();

    // Out-of-range position consumes the arm without flipping
    inj_arm = 1'b1;
    inj_pos = 4'd13;
    cycle();
    inj_arm = 1'b0;
    applyStimulus(1'b1, 4'd9, 8'hA5, 1'b1);
    cycle();
    checkOutput("inj_oor_code", 32'(bus.out_code), 32'hA27);
    drain();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
